// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg
//   Constants and types shared between the window buffer and the
//   past-sequence adder.
//   - DATA_WIDTH_DEF / N_DEF : default sample width and log2 window depth
//   - depth(n)               : window depth for a given log2 depth
//   - sample_t               : one sample at the default width
package seq_adder_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 4;
    localparam int unsigned N_DEF          = 2;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

    function automatic int unsigned depth(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/seq_window_ram.sv
// seq_window_ram
//   2**N-entry register array holding the sliding window. A single index is
//   used for both read and write; the read is combinational, so the value
//   seen on rdata in a write cycle is the pre-write content of that entry.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   clear      : synchronous clear of all entries (wins over we)
//   we         : write wdata into entry idx at the rising edge
//   idx        : shared read/write index
//   wdata      : write data
//   rdata      : current content of entry idx
module seq_window_ram
    import seq_adder_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH_DEF,
    parameter int unsigned N          = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  we,
    input  logic [N-1:0]          idx,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    localparam int unsigned DEPTH = depth(N);

    logic [data_width-1:0] mem [DEPTH];

    assign rdata = mem[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/seq_window_buffer.sv
// seq_window_buffer
//   Upstream feeder for the past-sequence adder. Keeps the last 2**N accepted
//   samples and, for each accepted sample, presents (newest, evicted, full)
//   through one registered valid/ready output stage so the adder can keep a
//   running sum as sum + new - old.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear of window, pointer, fill, out_valid
//   in_valid/in_ready    : input handshake; in_data is the sample
//   out_valid/out_ready  : output handshake
//   out_new              : sample just accepted
//   out_old              : sample evicted by that write (0 until window full)
//   out_full             : window held 2**N samples before that write
//   fill_level           : current fill count, only when
//                          SEQ_WINDOW_FILL_LEVEL_EN is defined
module seq_window_buffer
    import seq_adder_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH_DEF,
    parameter int unsigned N          = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_new,
    output logic [data_width-1:0] out_old,
`ifdef SEQ_WINDOW_FILL_LEVEL_EN
    output logic [N:0]            fill_level,
`endif
    output logic                  out_full
);

    localparam int unsigned DEPTH    = depth(N);
    localparam logic [N:0]  FILL_MAX = (N+1)'(DEPTH);

    logic [N-1:0]          wr_ptr;
    logic [N:0]            fill;
    logic [data_width-1:0] rd_data;
    logic                  accept;
    logic                  win_full;

    // Output stage frees up when empty or being consumed this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign win_full = (fill == FILL_MAX);

    seq_window_ram #(
        .data_width (data_width),
        .N          (N)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .we    (accept),
        .idx   (wr_ptr),
        .wdata (in_data),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_new   <= '0;
            out_old   <= '0;
            out_full  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_new   <= in_data;
            out_old   <= win_full ? rd_data : '0;
            out_full  <= win_full;
            out_valid <= 1'b1;
            wr_ptr    <= wr_ptr + 1'b1;
            if (!win_full) fill <= fill + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SEQ_WINDOW_FILL_LEVEL_EN
    assign fill_level = fill;
`endif

endmodule

// File: tb/tb_seq_window_buffer.sv
// tb_seq_window_buffer
//   Scoreboard bench for seq_window_buffer (default data_width 4, N 2).
//   The driver keeps the window as a queue of past samples and pushes the
//   expected (new, old, full) pair for every accepted sample; the monitor
//   compares the presented pair against the queue front on every cycle
//   out_valid is high and pops on consumption.
//   Build with SEQ_WINDOW_FILL_LEVEL_EN to also check fill_level.
module tb_seq_window_buffer;

    localparam int DW    = 4;
    localparam int NN    = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] nw;
        logic [DW-1:0] old;
        logic          full;
    } pair_t;

    logic          tb_clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_new;
    logic [DW-1:0] out_old;
    logic          out_full;
`ifdef SEQ_WINDOW_FILL_LEVEL_EN
    logic [NN:0]   fill_level;
`endif

    int checks = 0;
    int errors = 0;

    int unsigned hist[$];   // window contents, oldest first
    pair_t       sb[$];     // expected pairs, oldest first
    int          pushed_now = 0;
    logic        flush_now  = 1'b0;

    seq_window_buffer #(
        .data_width (DW),
        .N          (NN)
    ) dut (
        .clk        (tb_clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_new    (out_new),
        .out_old    (out_old),
`ifdef SEQ_WINDOW_FILL_LEVEL_EN
        .fill_level (fill_level),
`endif
        .out_full   (out_full)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive shortly after the edge, then update
    // the reference window for a sample that will be taken at the next edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d,
                         input logic r, input logic f);
        pair_t p;
        @(posedge tb_clk);
        #1;
`ifdef SEQ_WINDOW_FILL_LEVEL_EN
        chk("fill_level", int'(fill_level), hist.size());
`endif
        pushed_now = 0;
        flush_now  = f;
        in_valid   = v;
        in_data    = d;
        out_ready  = r;
        flush      = f;
        #1;
        if (f) begin
            hist.delete();
        end else if (v && in_ready) begin
            p.nw   = d;
            p.full = (hist.size() == DEPTH);
            p.old  = p.full ? DW'(hist[0]) : '0;
            if (p.full) void'(hist.pop_front());
            hist.push_back(int'(d));
            sb.push_back(p);
            pushed_now = 1;
        end
    endtask

    // Monitor: mid-cycle, outputs and this cycle's out_ready are stable.
    always @(negedge tb_clk) begin
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                if (sb.size() <= pushed_now) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got new=%0d old=%0d full=%0d, expected none",
                             out_new, out_old, out_full);
                end else begin
                    checks++;
                    if (out_new !== sb[0].nw || out_old !== sb[0].old || out_full !== sb[0].full) begin
                        errors++;
                        $display("FAIL pair: got (%0d,%0d,%0d) expected (%0d,%0d,%0d) at %0t",
                                 out_new, out_old, out_full, sb[0].nw, sb[0].old, sb[0].full, $time);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("no_drop_pending", sb.size() - pushed_now, 0);
            end
            if (flush_now) sb.delete();
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_new",   int'(out_new), 0);
        chk("reset_out_old",   int'(out_old), 0);
        chk("reset_out_full",  int'(out_full), 0);
        repeat (2) @(posedge tb_clk);
        #3 rst_n = 1'b1;
        #1 chk("reset_in_ready", int'(in_ready), 1);

        // Fill, then wrap: 1..6 gives (1,0,0)..(4,0,0) (5,1,1) (6,2,1).
        for (int i = 1; i <= 6; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);

        // Backpressure with a full window: 7 must evict 3 exactly once.
        cycle(1'b1, 4'd7, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 1'b0, 1'b0);
        chk("bp_in_ready", int'(in_ready), 0);
        cycle(1'b1, 4'd7, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);

        // Wrap-around: 0..11, old = k-4 once full.
        for (int i = 0; i < 12; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);

        // Flush mid-stream: 11 dropped, next pair starts an empty window.
        cycle(1'b1, 4'd9,  1'b1, 1'b0);
        cycle(1'b1, 4'd10, 1'b1, 1'b0);
        cycle(1'b1, 4'd11, 1'b1, 1'b1);
        @(posedge tb_clk);
        #1;
        chk("flush_out_valid", int'(out_valid), 0);
        in_valid = 1'b0; flush = 1'b0; flush_now = 1'b0; pushed_now = 0;
        cycle(1'b1, 4'd12, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(i + 1), 1'b1, 1'b0);

        // Async reset between edges while a pair is pending.
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        @(posedge tb_clk);
        #3;
        chk("pre_reset_out_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_out_new",   int'(out_new), 0);
        chk("async_out_old",   int'(out_old), 0);
        chk("async_out_full",  int'(out_full), 0);
        sb.delete(); hist.delete();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pushed_now = 0; flush_now = 1'b0;
        @(posedge tb_clk);
        #3 rst_n = 1'b1;
        cycle(1'b1, 4'd3, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);

        // Randomised traffic with occasional backpressure and flush.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  DW'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        // Drain with a bounded budget.
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            cycle(1'b0, 4'd0, 1'b1, 1'b0);
        end
        chk("drain_empty", sb.size(), 0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        @(posedge tb_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
